// File: rtl/mmu_ptw_walker.sv
// mmu_ptw_walker: two-level Sv32 hardware page-table walker.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   walk_req_i        walk request on TLB miss (taken only while idle)
//   walk_vaddr_i      virtual address (VPN1=[31:22], VPN0=[21:12])
//   walk_satp_ppn_i   root page-table PPN from satp
//   walk_is_store_i   access is a store (enables the D-bit check)
//   walk_ready_o      high while the walker is idle
//   flush_i           abort the current walk (sfence / satp write)
//   ptw_req_o         PTE read request to the PTW arbiter
//   ptw_addr_o        physical address of the PTE being read
//   ptw_data_i        PTE data, valid in the ack cycle only
//   ptw_ack_i         PTE read acknowledge
//   resp_valid_o      one-cycle response strobe
//   resp_pte_o        raw final PTE (also on a fault)
//   resp_superpage_o  result is a 4 MiB leaf
//   resp_fault_o      page fault
module mmu_ptw_walker (
  input  logic        clk,
  input  logic        rst,
  input  logic        walk_req_i,
  input  logic [31:0] walk_vaddr_i,
  input  logic [21:0] walk_satp_ppn_i,
  input  logic        walk_is_store_i,
  output logic        walk_ready_o,
  input  logic        flush_i,
  output logic        ptw_req_o,
  output logic [31:0] ptw_addr_o,
  input  logic [31:0] ptw_data_i,
  input  logic        ptw_ack_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_pte_o,
  output logic        resp_superpage_o,
  output logic        resp_fault_o
);

  typedef enum logic [2:0] {
    IDLE,
    L1_WAIT,
    L0_SETUP,
    L0_WAIT,
    RESP,
    DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  vpn0_q;
  logic        is_store_q;
  logic [31:0] ptw_addr_q;
  logic [31:0] resp_pte_q;
  logic        resp_superpage_q;
  logic        resp_fault_q;

  logic        accept;
  logic        load_l0;
  logic        load_resp;
  logic        fault_d;
  logic        super_d;

  // PTE fields of the incoming data
  logic pte_v, pte_r, pte_w, pte_x, pte_a, pte_d;
  logic pte_invalid, pte_leaf, leaf_fault, super_misaligned;

  // Physical addresses are 32 bits wide, so ppn[21:20] and the page offset
  // never contribute.
  logic unused_bits;
  assign unused_bits = ^{walk_satp_ppn_i[21:20], walk_vaddr_i[11:0]};

  assign pte_v = ptw_data_i[0];
  assign pte_r = ptw_data_i[1];
  assign pte_w = ptw_data_i[2];
  assign pte_x = ptw_data_i[3];
  assign pte_a = ptw_data_i[6];
  assign pte_d = ptw_data_i[7];

  assign pte_invalid      = !pte_v || (!pte_r && pte_w);
  assign pte_leaf         = pte_r || pte_x;
  assign leaf_fault       = !pte_a || (is_store_q && !pte_d);
  assign super_misaligned = |ptw_data_i[19:10];

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    load_l0   = 1'b0;
    load_resp = 1'b0;
    fault_d   = 1'b0;
    super_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (walk_req_i && !flush_i) begin
          state_d = L1_WAIT;
          accept  = 1'b1;
        end
      end
      L1_WAIT: begin
        if (ptw_ack_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else if (pte_invalid) begin
            state_d   = RESP;
            load_resp = 1'b1;
            fault_d   = 1'b1;
          end else if (pte_leaf) begin
            state_d   = RESP;
            load_resp = 1'b1;
            super_d   = 1'b1;
            fault_d   = leaf_fault || super_misaligned;
          end else begin
            state_d = L0_SETUP;
            load_l0 = 1'b1;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      // Idle cycle between levels so the arbiter can grant another master.
      L0_SETUP: begin
        state_d = flush_i ? IDLE : L0_WAIT;
      end
      L0_WAIT: begin
        if (ptw_ack_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            state_d   = RESP;
            load_resp = 1'b1;
            // a non-leaf at the last level is a fault as well
            fault_d   = pte_invalid || !pte_leaf || leaf_fault;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      // Outstanding read must complete before the arbiter is released.
      DRAIN: begin
        if (ptw_ack_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      vpn0_q           <= '0;
      is_store_q       <= 1'b0;
      ptw_addr_q       <= '0;
      resp_pte_q       <= '0;
      resp_superpage_q <= 1'b0;
      resp_fault_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        vpn0_q     <= walk_vaddr_i[21:12];
        is_store_q <= walk_is_store_i;
        ptw_addr_q <= {walk_satp_ppn_i[19:0], walk_vaddr_i[31:22], 2'b00};
      end
      if (load_l0) begin
        ptw_addr_q <= {ptw_data_i[29:10], vpn0_q, 2'b00};
      end
      if (load_resp) begin
        resp_pte_q       <= ptw_data_i;
        resp_superpage_q <= super_d;
        resp_fault_q     <= fault_d;
      end
    end
  end

  assign walk_ready_o     = (state_q == IDLE);
  assign ptw_req_o        = (state_q == L1_WAIT) || (state_q == L0_WAIT) ||
                            (state_q == DRAIN);
  assign ptw_addr_o       = ptw_addr_q;
  assign resp_valid_o     = (state_q == RESP) && !flush_i;
  assign resp_pte_o       = resp_pte_q;
  assign resp_superpage_o = resp_superpage_q;
  assign resp_fault_o     = resp_fault_q;

endmodule

// File: tb/tb_mmu_ptw_walker.sv
// tb_mmu_ptw_walker: scoreboard bench for mmu_ptw_walker. Stimulus tasks
// push the expected response with its due cycle; a negedge monitor pops and
// compares whenever resp_valid_o is seen.
module tb_mmu_ptw_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        walk_req_i;
  logic [31:0] walk_vaddr_i;
  logic [21:0] walk_satp_ppn_i;
  logic        walk_is_store_i;
  logic        walk_ready_o;
  logic        flush_i;
  logic        ptw_req_o;
  logic [31:0] ptw_addr_o;
  logic [31:0] ptw_data_i;
  logic        ptw_ack_i;
  logic        resp_valid_o;
  logic [31:0] resp_pte_o;
  logic        resp_superpage_o;
  logic        resp_fault_o;

  mmu_ptw_walker dut (
    .clk              (clk),
    .rst              (rst),
    .walk_req_i       (walk_req_i),
    .walk_vaddr_i     (walk_vaddr_i),
    .walk_satp_ppn_i  (walk_satp_ppn_i),
    .walk_is_store_i  (walk_is_store_i),
    .walk_ready_o     (walk_ready_o),
    .flush_i          (flush_i),
    .ptw_req_o        (ptw_req_o),
    .ptw_addr_o       (ptw_addr_o),
    .ptw_data_i       (ptw_data_i),
    .ptw_ack_i        (ptw_ack_i),
    .resp_valid_o     (resp_valid_o),
    .resp_pte_o       (resp_pte_o),
    .resp_superpage_o (resp_superpage_o),
    .resp_fault_o     (resp_fault_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] pte;
    logic        sup;
    logic        fault;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
  endtask

  always @(negedge clk) begin
    if (resp_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_pte", resp_pte_o, e.pte);
        chk("resp_superpage", {31'd0, resp_superpage_o}, {31'd0, e.sup});
        chk("resp_fault", {31'd0, resp_fault_o}, {31'd0, e.fault});
        chk("resp_cycle", cyc, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One walk with single-cycle acks; two=1 walks both levels.
  task automatic walk(input logic [31:0] va, input logic [21:0] ppn,
                      input logic st, input logic two,
                      input logic [31:0] d1, input logic [31:0] d0,
                      input logic [31:0] epte, input logic esup,
                      input logic efault, input logic flush_resp);
    int t;
    exp_t x;
    logic [31:0] a1, a0;
    a1 = {ppn[19:0], va[31:22], 2'b00};
    a0 = {d1[29:10], va[21:12], 2'b00};
    walk_req_i      = 1'b1;
    walk_vaddr_i    = va;
    walk_satp_ppn_i = ppn;
    walk_is_store_i = st;
    t = cyc;
    if (!flush_resp) begin
      x.pte = epte; x.sup = esup; x.fault = efault; x.due = t + (two ? 6 : 3);
      sb.push_back(x);
    end
    step();
    walk_req_i      = 1'b0;
    walk_vaddr_i    = ~va;
    walk_satp_ppn_i = ~ppn;
    walk_is_store_i = ~st;
    chk("l1_req", {31'd0, ptw_req_o}, 32'd1);
    chk("l1_addr", ptw_addr_o, a1);
    chk("busy", {31'd0, walk_ready_o}, 32'd0);
    step();
    ptw_ack_i  = 1'b1;
    ptw_data_i = d1;
    step();
    ptw_ack_i  = 1'b0;
    ptw_data_i = $urandom;
    if (two) begin
      chk("setup_req", {31'd0, ptw_req_o}, 32'd0);
      step();
      chk("l0_req", {31'd0, ptw_req_o}, 32'd1);
      chk("l0_addr", ptw_addr_o, a0);
      step();
      ptw_ack_i  = 1'b1;
      ptw_data_i = d0;
      step();
      ptw_ack_i  = 1'b0;
      ptw_data_i = $urandom;
    end
    if (flush_resp) begin
      flush_i = 1'b1;
      #1;
      chk("flush_resp_valid", {31'd0, resp_valid_o}, 32'd0);
      step();
      flush_i = 1'b0;
    end else begin
      step();
    end
    chk("ready_after", {31'd0, walk_ready_o}, 32'd1);
    chk("resp_pending", sb.size(), 32'd0);
  endtask

  // Start a walk to 0x4000_1234 / root 0x80 and stop at the L0_SETUP cycle.
  task automatic start_to_setup();
    walk_req_i      = 1'b1;
    walk_vaddr_i    = 32'h4000_1234;
    walk_satp_ppn_i = 22'h00080;
    walk_is_store_i = 1'b0;
    step();
    walk_req_i = 1'b0;
    step();
    ptw_ack_i  = 1'b1;
    ptw_data_i = 32'h0002_0401;
    step();
    ptw_ack_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] va;
    logic [21:0] ppn;
    logic        st, flt;

    rst = 1'b1; walk_req_i = 1'b0; walk_vaddr_i = '0; walk_satp_ppn_i = '0;
    walk_is_store_i = 1'b0; flush_i = 1'b0; ptw_data_i = '0; ptw_ack_i = 1'b0;
    repeat (3) step();
    chk("rst_ready", {31'd0, walk_ready_o}, 32'd1);
    chk("rst_req", {31'd0, ptw_req_o}, 32'd0);
    chk("rst_addr", ptw_addr_o, 32'd0);
    chk("rst_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_pte", resp_pte_o, 32'd0);
    chk("rst_flags", {30'd0, resp_superpage_o, resp_fault_o}, 32'd0);
    rst = 1'b0;
    step();

    // two-level hit, then response registers hold in idle
    walk(32'h4000_1234, 22'h00080, 1'b0, 1'b1, 32'h0002_0401, 32'h048D_14CF,
         32'h048D_14CF, 1'b0, 1'b0, 1'b0);
    step();
    chk("pte_hold", resp_pte_o, 32'h048D_14CF);
    // superpages
    walk(32'h4000_1234, 22'h00080, 1'b0, 1'b0, 32'h2000_00CF, 32'h0,
         32'h2000_00CF, 1'b1, 1'b0, 1'b0);
    walk(32'h4000_1234, 22'h00080, 1'b0, 1'b0, 32'h0000_04CF, 32'h0,
         32'h0000_04CF, 1'b1, 1'b1, 1'b0);
    // invalid at L1, non-leaf at L0
    walk(32'h4000_1234, 22'h00080, 1'b0, 1'b0, 32'h0000_0005, 32'h0,
         32'h0000_0005, 1'b0, 1'b1, 1'b0);
    walk(32'h4000_1234, 22'h00080, 1'b0, 1'b1, 32'h0002_0401, 32'h0000_0001,
         32'h0000_0001, 1'b0, 1'b1, 1'b0);
    // D-bit check
    walk(32'h4000_1234, 22'h00080, 1'b1, 1'b1, 32'h0002_0401, 32'h048D_144F,
         32'h048D_144F, 1'b0, 1'b1, 1'b0);
    walk(32'h4000_1234, 22'h00080, 1'b0, 1'b1, 32'h0002_0401, 32'h048D_144F,
         32'h048D_144F, 1'b0, 1'b0, 1'b0);
    // flush in RESP suppresses the strobe
    walk(32'h4000_1234, 22'h00080, 1'b0, 1'b0, 32'h2000_00CF, 32'h0,
         32'h2000_00CF, 1'b1, 1'b0, 1'b1);

    // flush in IDLE drops the request
    walk_req_i = 1'b1; flush_i = 1'b1;
    step();
    walk_req_i = 1'b0; flush_i = 1'b0;
    chk("idle_flush_ready", {31'd0, walk_ready_o}, 32'd1);
    chk("idle_flush_req", {31'd0, ptw_req_o}, 32'd0);

    // flush coincident with L1 ack
    walk_req_i = 1'b1; walk_vaddr_i = 32'h4000_1234; walk_satp_ppn_i = 22'h80;
    step();
    walk_req_i = 1'b0;
    step();
    ptw_ack_i = 1'b1; ptw_data_i = 32'h2000_00CF; flush_i = 1'b1;
    step();
    ptw_ack_i = 1'b0; flush_i = 1'b0;
    chk("ackflush_ready", {31'd0, walk_ready_o}, 32'd1);
    chk("ackflush_req", {31'd0, ptw_req_o}, 32'd0);

    // flush in L0_SETUP
    start_to_setup();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("setupflush_ready", {31'd0, walk_ready_o}, 32'd1);
    step();
    chk("setupflush_noreq", {31'd0, ptw_req_o}, 32'd0);

    // flush in L0_WAIT, ack delayed 5 cycles
    start_to_setup();
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_req", {31'd0, ptw_req_o}, 32'd1);
      chk("drain_addr", ptw_addr_o, 32'h0008_1004);
      step();
    end
    chk("drain_req", {31'd0, ptw_req_o}, 32'd1);
    ptw_ack_i = 1'b1; ptw_data_i = 32'h048D_14CF; walk_req_i = 1'b1;
    step();
    ptw_ack_i = 1'b0; walk_req_i = 1'b0;
    chk("drain_done_ready", {31'd0, walk_ready_o}, 32'd1);
    chk("drain_done_req", {31'd0, ptw_req_o}, 32'd0);
    step();
    chk("drain_req_ignored", {31'd0, walk_ready_o}, 32'd1);

    // reset in L1_WAIT, late ack ignored
    walk_req_i = 1'b1; walk_vaddr_i = 32'h4000_1234; walk_satp_ppn_i = 22'h80;
    step();
    walk_req_i = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstwalk_ready", {31'd0, walk_ready_o}, 32'd1);
    chk("rstwalk_req", {31'd0, ptw_req_o}, 32'd0);
    chk("rstwalk_addr", ptw_addr_o, 32'd0);
    chk("rstwalk_pte", resp_pte_o, 32'd0);
    ptw_ack_i = 1'b1; ptw_data_i = 32'h2000_00CF;
    step();
    ptw_ack_i = 1'b0;
    repeat (4) step();
    chk("rstwalk_idle", {31'd0, walk_ready_o}, 32'd1);

    // random level-1 leaves, including truncated root PPN bits
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      d[1:0] = 2'b11;
      if (i % 2 == 0) d[19:10] = '0;
      st  = 1'($urandom_range(0, 1));
      va  = $urandom;
      ppn = 22'($urandom);
      flt = !d[6] || (st && !d[7]) || (d[19:10] != 10'd0);
      walk(va, ppn, st, 1'b0, d, 32'h0, d, 1'b1, flt, 1'b0);
    end

    repeat (3) step();
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmu_ptw_walker.md
MMU_PTW_WALKER -- requirements
Module: mmu_ptw_walker

Interface
REQ-001 Parameters: none; Sv32 only; all widths are fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 walk_req_i  in  1  walk request from TLB miss; accepted only in IDLE.
REQ-005 walk_vaddr_i  in  32  virtual address; VPN1=[31:22], VPN0=[21:12].
REQ-006 walk_satp_ppn_i  in  22  root page-table PPN from satp.
REQ-007 walk_is_store_i  in  1  the access is a store; used for the D-bit check.
REQ-008 walk_ready_o  out  1  high exactly when state is IDLE.
REQ-009 flush_i  in  1  abort the current walk (sfence/satp write).
REQ-010 ptw_req_o / ptw_addr_o  out  1/32  PTE read request and physical address, to the PTW arbiter.
REQ-011 ptw_data_i / ptw_ack_i  in  32/1  PTE data, valid only in the ack cycle.
REQ-012 resp_valid_o  out  1  one-cycle response strobe.
REQ-013 resp_pte_o / resp_superpage_o / resp_fault_o  out  32/1/1  final PTE, 4 MiB leaf flag, page-fault flag.

Function
REQ-014 The walker SHALL use states IDLE, L1_WAIT, L0_SETUP, L0_WAIT, RESP and DRAIN.
REQ-015 In IDLE, a request with walk_req_i=1 and flush_i=0 SHALL latch vaddr, satp_ppn and is_store, set ptw_addr_o={ppn[19:0],VPN1,2'b00}, and enter L1_WAIT.
REQ-016 Physical addresses SHALL truncate to 32 bits; ppn[21:20] SHALL be ignored.
REQ-017 ptw_req_o SHALL equal (state==L1_WAIT | L0_WAIT | DRAIN) and SHALL stay high through the ack cycle inclusive.
REQ-018 ptw_addr_o SHALL be registered and stable whenever ptw_req_o=1.
REQ-019 ptw_ack_i SHALL be ignored while ptw_req_o=0; ack arrives no earlier than the cycle after ptw_req_o rises.
REQ-020 On ack in L1_WAIT or L0_WAIT, the walker SHALL classify ptw_data_i as follows (V=0 R=1 W=2 X=3 A=6 D=7, PPN=[31:10]):
- Invalid when V=0 or (R=0 & W=1): go to RESP with fault.
- Leaf when R|X=1: go to RESP; fault if A=0 or (is_store & D=0).
- Non-leaf in L1_WAIT: set ptw_addr_o={pte[29:10],VPN0,2'b00}, enter L0_SETUP.
- Non-leaf in L0_WAIT: go to RESP with fault.
REQ-021 A leaf in L1_WAIT SHALL set superpage=1 and SHALL fault if pte[19:10]!=0 (misaligned superpage).
REQ-022 L0_SETUP SHALL last exactly one cycle with ptw_req_o=0, then enter L0_WAIT. This releases the arbiter between levels.
REQ-023 RESP SHALL last one cycle with resp_valid_o=1, then enter IDLE. resp_pte_o SHALL be the raw final PTE, including on a fault.
REQ-024 resp_* outputs SHALL be registered and hold their values outside RESP; only resp_valid_o qualifies them.
REQ-025 Latency with 1-cycle ack, request accepted at cycle T: ptw_req_o high at T+1, and the walker returns resp_valid_o at:
- T+3 for a level-1 result.
- T+6 for a level-0 result.
REQ-026 flush_i handling, by state:
- L1_WAIT/L0_WAIT without ack: go to DRAIN, keep ptw_req_o and ptw_addr_o until ack, then go to IDLE without a response.
- Flush coincident with ack: go to IDLE, no response.
- L0_SETUP: go to IDLE, no request issued.
- RESP: resp_valid_o is forced 0.
- IDLE: flush overrides walk_req_i, which is dropped.
REQ-027 DRAIN SHALL ignore walk_req_i and ptw_data_i.

Reset
REQ-028 On rst the walker SHALL enter IDLE and clear ptw_req_o, ptw_addr_o, resp_valid_o, resp_pte_o, resp_superpage_o and resp_fault_o. rst overrides every other input.
REQ-029 Reset mid-walk SHALL drop ptw_req_o at the next edge with no response. The system resets the arbiter and DCache together with the walker.

Verification
REQ-030 Two-level hit: satp_ppn=0x00080, vaddr=0x4000_1234, 1-cycle ack.
- L1 addr=0x0008_0400, data=0x0002_0401.
- L0_SETUP cycle with req=0.
- L0 addr=0x0008_1004, data=0x048D_14CF.
- Required: resp at T+6 with pte=0x048D_14CF, superpage=0, fault=0.
REQ-031 Superpage: L1 data 0x2000_00CF returns superpage=1, fault=0 at T+3. L1 data 0x0000_04CF returns fault=1, superpage=1.
REQ-032 Invalid and non-leaf faults:
- L1 data 0x0000_0005 (W without R) returns fault=1 at T+3.
- L0 data 0x0000_0001 (non-leaf) returns fault=1.
REQ-033 D-bit check: leaf 0x048D_144F returns fault=1 with is_store=1 and fault=0 with is_store=0.
REQ-034 Flush in L0_WAIT with ack delayed 5 cycles:
- ptw_req_o stays 1 with addr unchanged until ack.
- resp_valid_o never asserts.
- walk_ready_o=1 the cycle after ack.
REQ-035 rst asserted in L1_WAIT returns walk_ready_o=1 and ptw_req_o=0 at the next edge; a late ack is ignored and no response follows.
